// File: rtl/fmdll_pkg.sv
// Shared FMDLL definitions: divider FSM states and the M/N ratio legality rule
// that the divider and the FMDLL configuration checker both rely on.
package fmdll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } div_state_t;

    localparam int unsigned N_LEGAL_CNT = 5;
    localparam int unsigned N_LEGAL [N_LEGAL_CNT] = '{1, 4, 5, 8, 10};

    // M must be 1..3, N must be a supported denominator, and M may not exceed N.
    function automatic logic ratio_legal(input int unsigned m, input int unsigned n);
        logic n_ok;
        n_ok = 1'b0;
        for (int i = 0; i < N_LEGAL_CNT; i++) begin
            if (n == N_LEGAL[i]) n_ok = 1'b1;
        end
        return n_ok && (m >= 1) && (m <= 3) && (m <= n);
    endfunction

endpackage

// File: rtl/fmdll_frac_div_if.sv
// Configuration and output bundle of the fractional reference divider.
interface fmdll_frac_div_if #(
    parameter int NW = 4,
    parameter int MW = 2
);
    logic [MW-1:0] M;
    logic [NW-1:0] N;
    logic          cfg_load;
    logic          div_en;
    logic          clk_div;
    logic [MW-1:0] Sel;
    logic          active;
    logic          cfg_err;

    modport master (
        output M, N, cfg_load,
        input  div_en, clk_div, Sel, active, cfg_err
    );

    modport slave (
        input  M, N, cfg_load,
        output div_en, clk_div, Sel, active, cfg_err
    );
endinterface

// File: rtl/frac_acc.sv
// Fractional phase accumulator: adds m_r each enabled cycle and wraps modulo n_r,
// flagging hit on the cycles where the wrap happens.
module frac_acc #(
    parameter int NW = 4,
    parameter int MW = 2
) (
    input  logic          clk_ext,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [MW-1:0] m_r,
    input  logic [NW-1:0] n_r,
    output logic          hit
);
    localparam int AW = NW + 1;

    logic [NW-1:0] acc;
    logic [AW-1:0] sum;
    logic [AW-1:0] diff;

    assign sum  = {1'b0, acc} + AW'(m_r);
    assign diff = sum - {1'b0, n_r};
    assign hit  = en && (sum >= {1'b0, n_r});

    // acc < n_r always holds, so the post-wrap value fits back into NW bits.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= hit ? diff[NW-1:0] : sum[NW-1:0];
        end
    end

endmodule

// File: rtl/fmdll_frac_div.sv
// Fractional reference divider: M enable pulses per N clk_ext cycles, a divided
// clock toggling on each pulse, and the pulse index within the M-pulse pattern.
module fmdll_frac_div
    import fmdll_pkg::*;
#(
    parameter int NW = 4,
    parameter int MW = 2
) (
    input  logic       clk_ext,
    input  logic       rst_n,
    fmdll_frac_div_if.slave bus
);
    // state | meaning
    // IDLE  | after reset, no ratio loaded, outputs quiet
    // RUN   | legal ratio loaded, accumulator running, pulses emitted
    // ERR   | illegal ratio loaded, outputs quiet until a legal load

    div_state_t    state;
    logic [MW-1:0] m_r;
    logic [NW-1:0] n_r;
    logic          div_en;
    logic          clk_div;
    logic [MW-1:0] sel;
    logic          first_pulse;
    logic          hit;
    logic          acc_en;
    logic          acc_clr;

    assign acc_en  = (state == RUN) && !bus.cfg_load;
    assign acc_clr = bus.cfg_load || (state != RUN);

    frac_acc #(.NW(NW), .MW(MW)) u_acc (
        .clk_ext (clk_ext),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .m_r     (m_r),
        .n_r     (n_r),
        .hit     (hit)
    );

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_r         <= '0;
            n_r         <= '0;
            div_en      <= 1'b0;
            clk_div     <= 1'b0;
            sel         <= '0;
            first_pulse <= 1'b1;
        end else if (bus.cfg_load) begin
            m_r         <= bus.M;
            n_r         <= bus.N;
            div_en      <= 1'b0;
            clk_div     <= 1'b0;
            sel         <= '0;
            first_pulse <= 1'b1;
            state       <= ratio_legal(int'(bus.M), int'(bus.N)) ? RUN : ERR;
        end else begin
            case (state)
                RUN: begin
                    div_en <= hit;
                    if (hit) begin
                        clk_div     <= ~clk_div;
                        first_pulse <= 1'b0;
                        // Sel names the pulse just emitted, so the first one is index 0.
                        if (first_pulse || (sel == m_r - MW'(1))) sel <= '0;
                        else                                      sel <= sel + MW'(1);
                    end
                end
                default: begin
                    div_en  <= 1'b0;
                    clk_div <= 1'b0;
                    sel     <= '0;
                end
            endcase
        end
    end

    assign bus.div_en  = div_en;
    assign bus.clk_div = clk_div;
    assign bus.Sel     = sel;
    assign bus.active  = (state == RUN);
    assign bus.cfg_err = (state == ERR);

endmodule

// File: tb/tb_fmdll_frac_div.sv
// Self-checking bench for fmdll_frac_div: ratio table, random ratios against a
// pulse-count model, plus reset and load-collision sequences.
module tb_fmdll_frac_div;

    logic clk_ext = 1'b0;
    logic rst_n   = 1'b0;

    fmdll_frac_div_if #(.NW(4), .MW(2)) bus ();

    fmdll_frac_div #(.NW(4), .MW(2)) dut (
        .clk_ext (clk_ext),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_ext = ~clk_ext;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int m;
        int n;
        bit legal;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_legal(input int m, input int n);
        bit n_ok;
        n_ok = (n == 1) || (n == 4) || (n == 5) || (n == 8) || (n == 10);
        return n_ok && m >= 1 && m <= 3 && m <= n;
    endfunction

    // Load at the next edge; returns 1 ns after it with random live M/N on the bus.
    task automatic do_load(input int m, input int n);
        @(posedge clk_ext); #1;
        bus.M        = 2'(m);
        bus.N        = 4'(n);
        bus.cfg_load = 1'b1;
        @(posedge clk_ext); #1;
        bus.cfg_load = 1'b0;
        bus.M        = 2'($urandom);
        bus.N        = 4'($urandom);
    endtask

    // Cycle t after load has emitted floor(t*M/N) pulses; acc is t*M mod N.
    task automatic run_check(input int m, input int n, input int cycles);
        int p_now, p_prev;
        for (int t = 1; t <= cycles; t++) begin
            @(posedge clk_ext); #1;
            p_now  = (t * m) / n;
            p_prev = ((t - 1) * m) / n;
            check("div_en",  int'(bus.div_en),  (p_now > p_prev) ? 1 : 0);
            check("clk_div", int'(bus.clk_div), p_now % 2);
            check("Sel",     int'(bus.Sel),     (p_now == 0) ? 0 : (p_now - 1) % m);
            check("acc",     int'(dut.u_acc.acc), (t * m) % n);
            check("active",  int'(bus.active),  1);
            if ((t % 4) == 0) begin
                bus.M = 2'($urandom);
                bus.N = 4'($urandom);
            end
        end
    endtask

    task automatic hold_err(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            @(posedge clk_ext); #1;
            check("err_div_en",  int'(bus.div_en),  0);
            check("err_clk_div", int'(bus.clk_div), 0);
            check("err_Sel",     int'(bus.Sel),     0);
            check("err_acc",     int'(dut.u_acc.acc), 0);
            check("err_cfg_err", int'(bus.cfg_err), 1);
            check("err_active",  int'(bus.active),  0);
        end
    endtask

    vec_t vecs [17];
    int   legal_n [5] = '{1, 4, 5, 8, 10};

    initial begin
        vecs = '{
            '{3, 8, 1}, '{2, 10, 1}, '{3, 4, 1}, '{1, 1, 1}, '{1, 3, 0},
            '{2, 1, 0}, '{2, 5, 1},  '{0, 4, 0}, '{1, 4, 1}, '{2, 8, 1},
            '{3, 5, 1}, '{3, 10, 1}, '{1, 5, 1}, '{3, 1, 0}, '{2, 4, 1},
            '{1, 10, 1}, '{1, 8, 1}
        };
        bus.M        = '0;
        bus.N        = '0;
        bus.cfg_load = 1'b0;

        #12;
        check("rst_div_en",  int'(bus.div_en),  0);
        check("rst_clk_div", int'(bus.clk_div), 0);
        check("rst_Sel",     int'(bus.Sel),     0);
        check("rst_active",  int'(bus.active),  0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk_ext); #1;
            check("idle_div_en", int'(bus.div_en), 0);
        end

        foreach (vecs[i]) begin
            do_load(vecs[i].m, vecs[i].n);
            check("tbl_active",  int'(bus.active),  vecs[i].legal ? 1 : 0);
            check("tbl_cfg_err", int'(bus.cfg_err), vecs[i].legal ? 0 : 1);
            if (vecs[i].legal) run_check(vecs[i].m, vecs[i].n, 2 * vecs[i].n + 2);
            else               hold_err(8);
        end

        // A load landing on a due pulse wins and restarts the pattern.
        foreach (legal_n[i]) begin
            if (i < 3) begin
                int due;
                due = (i == 0) ? 3 : (i == 1) ? 6 : 8;
                do_load(3, 8);
                repeat (due - 1) @(posedge clk_ext);
                #1;
                bus.M        = 2'd3;
                bus.N        = 4'd8;
                bus.cfg_load = 1'b1;
                @(posedge clk_ext); #1;
                bus.cfg_load = 1'b0;
                check("col_div_en",  int'(bus.div_en),  0);
                check("col_clk_div", int'(bus.clk_div), 0);
                check("col_Sel",     int'(bus.Sel),     0);
                check("col_acc",     int'(dut.u_acc.acc), 0);
                check("col_active",  int'(bus.active),  1);
                run_check(3, 8, 16);
            end
        end

        for (int it = 0; it < 25; it++) begin
            int m, n;
            bit lg;
            m  = int'($urandom_range(0, 3));
            n  = (it % 2 == 0) ? legal_n[$urandom_range(0, 4)] : int'($urandom_range(0, 15));
            lg = model_legal(m, n);
            do_load(m, n);
            check("rnd_active",  int'(bus.active),  lg ? 1 : 0);
            check("rnd_cfg_err", int'(bus.cfg_err), lg ? 0 : 1);
            if (lg) run_check(m, n, 2 * n + 3);
            else    hold_err(4);
        end

        // Asynchronous reset in the middle of a pulse, with the clock running.
        do_load(3, 8);
        repeat (3) @(posedge clk_ext);
        #3;
        check("pre_rst_div_en",  int'(bus.div_en),  1);
        check("pre_rst_clk_div", int'(bus.clk_div), 1);
        rst_n = 1'b0;
        #1;
        check("arst_div_en",  int'(bus.div_en),  0);
        check("arst_clk_div", int'(bus.clk_div), 0);
        check("arst_Sel",     int'(bus.Sel),     0);
        check("arst_active",  int'(bus.active),  0);
        check("arst_cfg_err", int'(bus.cfg_err), 0);
        check("arst_acc",     int'(dut.u_acc.acc), 0);
        #19;
        rst_n = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk_ext); #1;
            check("post_rst_div_en", int'(bus.div_en), 0);
            check("post_rst_active", int'(bus.active), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
